rat_io_hub: RTL and testbench
=============================

Name: rat_io_hub

Overview:
- Parametrised port-mapped I/O peripheral for the RAT MCU port bus (PORT_ID / OUT_PORT / IN_PORT / IO_STRB).
- Replaces hand-written per-wrapper output-register and input-mux logic with:
  - NUM_OUT addressable output registers, each with a write-strobe pulse.
  - NUM_IN synchronised input channels.
  - An event/interrupt controller: NUM_EVT edge-triggered sources, a maskable pending register, and a single INTERRUPT line to the MCU.

Parameters:
- NUM_OUT, 4, number of 8-bit output registers (1..8)
- NUM_IN, 4, number of 8-bit input channels (1..8)
- NUM_EVT, 4, number of event sources (1..8)
- OUT_BASE, 8'h40, PORT_ID of output register 0; register k at OUT_BASE+k
- IN_BASE, 8'h20, PORT_ID of input channel 0; channel k at IN_BASE+k
- IRQ_STATUS_ID, 8'hF0, pending register (read; write-1-to-clear)
- IRQ_MASK_ID, 8'hF1, interrupt mask register (read/write)
- SYNC_STAGES, 2, synchroniser depth for GPI and EVT (>=2)

Ports:
- CLK  in  1  system clock (MCU clock domain)
- RESET  in  1  reset; asynchronous, active-high
- PORT_ID  in  8  port address from MCU
- OUT_PORT  in  8  write data from MCU
- IO_STRB  in  1  write strobe from MCU, one cycle per OUTPUT instruction
- IN_PORT  out  8  read data to MCU, combinational from PORT_ID
- GPI  in  NUM_IN*8  asynchronous input channels; channel k = GPI[8k+7:8k]
- GPO  out  NUM_OUT*8  output registers; register k = GPO[8k+7:8k]
- WR_PULSE  out  NUM_OUT  one-cycle pulse per register write
- EVT  in  NUM_EVT  asynchronous event sources (buttons, sensors)
- INTERRUPT  out  1  registered level interrupt to MCU

Behaviour:
- Reset, asynchronous, all values 0:
  - GPO, WR_PULSE, mask, pending, INTERRUPT
  - all synchroniser flops and edge-detect flops
- Write:
  - On a rising CLK edge with IO_STRB=1 and PORT_ID=OUT_BASE+k (k<NUM_OUT), GPO reg k <= OUT_PORT.
  - WR_PULSE[k] is high for exactly the following cycle, registered.
  - Back-to-back writes produce back-to-back pulses.
- Mask write: IO_STRB=1 with PORT_ID=IRQ_MASK_ID -> mask <= OUT_PORT[NUM_EVT-1:0].
- Status write: IO_STRB=1 with PORT_ID=IRQ_STATUS_ID -> pending bits where OUT_PORT=1 are cleared (W1C); zero bits are unaffected.
- Writes to unmapped IDs, or to IN_BASE range IDs, have no effect.
- Decode priority: IRQ_STATUS_ID and IRQ_MASK_ID, then the OUT range, then the IN range. Overlapping ranges resolve by this order.
- Read (combinational IN_PORT):
  - IN_BASE+k (k<NUM_IN) -> synchronised GPI channel k
  - IRQ_STATUS_ID -> {0, pending}
  - IRQ_MASK_ID -> {0, mask}
  - everything else -> 8'h00
- Synchroniser:
  - Each GPI bit and each EVT bit passes through SYNC_STAGES flops.
  - GPI read latency is SYNC_STAGES cycles from pin to IN_PORT.
- Event detection:
  - A rising edge on a synchronised EVT bit (current 1, previous 0) sets pending[i] on the next edge.
  - Falling edges are ignored.
  - An EVT held high continuously sets pending once.
- Simultaneous set and W1C on the same bit in the same cycle: set wins, bit stays 1.
- INTERRUPT:
  - Registered: INTERRUPT <= |(pending & mask).
  - Latency from EVT rising at the pin to INTERRUPT high is SYNC_STAGES+2 cycles when the bit is unmasked.
  - Unmasking an already-pending bit raises INTERRUPT 1 cycle after the mask write.
  - Masking or clearing lowers it 1 cycle after the write.
- Events on masked bits still set pending (pollable via IRQ_STATUS_ID).
- Reset asserted mid-operation clears everything immediately; no write in flight completes.
  - Because the synchronisers clear to 0, an EVT held high across reset release sets pending SYNC_STAGES+1 cycles after release.
- Parameter values outside their ranges are rejected at elaboration.

Optional Feature:
- Macro: RAT_IO_READBACK_EN
- Defined: a read of OUT_BASE+k (k<NUM_OUT) returns GPO reg k. Priority is below the IRQ IDs and above the IN range.
- Undefined: OUT range IDs read 8'h00, and no readback mux is built.
- Write behaviour is identical in both builds.

Test Plan:
- Reset, then IO_STRB with PORT_ID=8'h42, OUT_PORT=8'hA5 -> GPO[23:16]=8'hA5 next cycle; WR_PULSE=4'b0100 for exactly 1 cycle; all other GPO bytes remain 0.
- GPI[15:8]=8'h3C, PORT_ID=8'h21 -> IN_PORT=8'h3C after 2 cycles; PORT_ID=8'h55 -> IN_PORT=8'h00.
- Mask write 8'h01, then EVT[0] rising -> pending=0x01 and INTERRUPT high 4 cycles after the edge. W1C write 8'h01 to 8'hF0 -> INTERRUPT low 1 cycle later.
- EVT[2] rises while mask=0 -> pending=0x04 and INTERRUPT stays 0. Mask write 8'h04 -> INTERRUPT=1 one cycle after.
- New EVT[1] edge arrives in the same cycle as W1C of bit 1 -> pending[1] remains 1.
- RESET pulsed mid-sequence with GPO=8'hFF and pending=0x0F -> all outputs 0 asynchronously. With RAT_IO_READBACK_EN defined, PORT_ID=8'h40 after a write of 8'h77 -> IN_PORT=8'h77; undefined -> 8'h00.

Source files
------------

// File: rtl/rat_io_hub.sv
// Port-mapped I/O hub for the RAT MCU: output registers with write pulses,
// synchronised inputs and a maskable edge-event interrupt controller.
// Optional readback of output registers on IN_PORT: define RAT_IO_READBACK_EN.
module rat_io_hub #(
  parameter int unsigned NUM_OUT       = 4,
  parameter int unsigned NUM_IN        = 4,
  parameter int unsigned NUM_EVT       = 4,
  parameter logic [7:0]  OUT_BASE      = 8'h40,
  parameter logic [7:0]  IN_BASE       = 8'h20,
  parameter logic [7:0]  IRQ_STATUS_ID = 8'hF0,
  parameter logic [7:0]  IRQ_MASK_ID   = 8'hF1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [7:0]           PORT_ID,
  input  logic [7:0]           OUT_PORT,
  input  logic                 IO_STRB,
  output logic [7:0]           IN_PORT,
  input  logic [NUM_IN*8-1:0]  GPI,
  output logic [NUM_OUT*8-1:0] GPO,
  output logic [NUM_OUT-1:0]   WR_PULSE,
  input  logic [NUM_EVT-1:0]   EVT,
  output logic                 INTERRUPT
);

  if ((NUM_OUT < 1) || (NUM_OUT > 8)) begin : g_bad_num_out
    $error("rat_io_hub: NUM_OUT must be 1..8");
  end
  if ((NUM_IN < 1) || (NUM_IN > 8)) begin : g_bad_num_in
    $error("rat_io_hub: NUM_IN must be 1..8");
  end
  if ((NUM_EVT < 1) || (NUM_EVT > 8)) begin : g_bad_num_evt
    $error("rat_io_hub: NUM_EVT must be 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rat_io_hub: SYNC_STAGES must be >= 2");
  end
  if ((32'(OUT_BASE) + NUM_OUT) > 256) begin : g_bad_out_base
    $error("rat_io_hub: OUT range exceeds 8-bit port space");
  end
  if ((32'(IN_BASE) + NUM_IN) > 256) begin : g_bad_in_base
    $error("rat_io_hub: IN range exceeds 8-bit port space");
  end

  // Address decode
  logic [7:0] out_off;
  logic [7:0] in_off;
  logic       status_hit;
  logic       mask_hit;
  logic       out_hit;
  logic       in_hit;

  assign out_off    = PORT_ID - OUT_BASE;
  assign in_off     = PORT_ID - IN_BASE;
  assign status_hit = (PORT_ID == IRQ_STATUS_ID);
  assign mask_hit   = (PORT_ID == IRQ_MASK_ID) && !status_hit;
  assign out_hit    = !status_hit && !mask_hit && (32'(out_off) < NUM_OUT);
  assign in_hit     = !status_hit && !mask_hit && !out_hit && (32'(in_off) < NUM_IN);

  // Output registers and write pulses
  logic [NUM_OUT-1:0]      out_we;
  logic [NUM_OUT-1:0][7:0] gpo_q;
  logic [NUM_OUT-1:0]      wr_pulse_q;

  always_comb begin
    out_we = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (IO_STRB && out_hit && (out_off == 8'(k))) out_we[k] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gpo_q      <= '0;
      wr_pulse_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (out_we[k]) gpo_q[k] <= OUT_PORT;
      end
      wr_pulse_q <= out_we;
    end
  end

  assign GPO      = gpo_q;
  assign WR_PULSE = wr_pulse_q;

  // Input and event synchronisers: stage 0 samples the pin
  logic [SYNC_STAGES-1:0][NUM_IN*8-1:0] gpi_sync;
  logic [SYNC_STAGES-1:0][NUM_EVT-1:0]  evt_sync;
  logic [NUM_IN-1:0][7:0]               gpi_ch;
  logic [NUM_EVT-1:0]                   evt_s;
  logic [NUM_EVT-1:0]                   evt_prev;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gpi_sync <= '0;
      evt_sync <= '0;
      evt_prev <= '0;
    end else begin
      gpi_sync <= {gpi_sync[SYNC_STAGES-2:0], GPI};
      evt_sync <= {evt_sync[SYNC_STAGES-2:0], EVT};
      evt_prev <= evt_s;
    end
  end

  assign gpi_ch = gpi_sync[SYNC_STAGES-1];
  assign evt_s  = evt_sync[SYNC_STAGES-1];

  // Event controller; a new edge beats a same-cycle W1C
  logic [NUM_EVT-1:0] rise;
  logic [NUM_EVT-1:0] clr;
  logic [NUM_EVT-1:0] pending_q;
  logic [NUM_EVT-1:0] mask_q;
  logic               irq_q;

  assign rise = evt_s & ~evt_prev;
  assign clr  = (IO_STRB && status_hit) ? OUT_PORT[NUM_EVT-1:0] : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
      if (IO_STRB && mask_hit) mask_q <= OUT_PORT[NUM_EVT-1:0];
      irq_q <= |(pending_q & mask_q);
    end
  end

  assign INTERRUPT = irq_q;

  // Read mux
  logic [7:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (status_hit) begin
      rd_data[NUM_EVT-1:0] = pending_q;
    end else if (mask_hit) begin
      rd_data[NUM_EVT-1:0] = mask_q;
    end
`ifdef RAT_IO_READBACK_EN
    else if (out_hit) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (out_off == 8'(k)) rd_data = gpo_q[k];
      end
    end
`endif
    else if (in_hit) begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        if (in_off == 8'(k)) rd_data = gpi_ch[k];
      end
    end
  end

  assign IN_PORT = rd_data;

endmodule

// File: tb/tb_rat_io_hub.sv
// Directed self-checking bench for rat_io_hub (default parameters).
module tb_rat_io_hub;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [7:0]  IN_PORT;
  logic [31:0] GPI;
  logic [31:0] GPO;
  logic [3:0]  WR_PULSE;
  logic [3:0]  EVT;
  logic        INTERRUPT;

  int tests = 0;
  int fails = 0;

  rat_io_hub dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .GPI(GPI), .GPO(GPO),
    .WR_PULSE(WR_PULSE), .EVT(EVT), .INTERRUPT(INTERRUPT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    PORT_ID = id; OUT_PORT = data; IO_STRB = 1'b1;
    tick();
    IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
  endtask

  task automatic setid(input logic [7:0] id);
    PORT_ID = id;
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (GPO !== 32'h0) begin fails++; $display("FAIL reset_gpo got %h want %h", GPO, 32'h0); end
    tests++; if (WR_PULSE !== 4'h0) begin fails++; $display("FAIL reset_pulse got %b want 0000", WR_PULSE); end
    tests++; if (INTERRUPT !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", INTERRUPT); end
    setid(8'hF1);
    tests++; if (IN_PORT !== 8'h00) begin fails++; $display("FAIL reset_mask got %h want 00", IN_PORT); end
    tick(); tick();
    RESET = 1'b0; PORT_ID = 8'h00;
    tick();
  endtask

  task automatic test_write();
    wr(8'h42, 8'hA5);
    tests++; if (GPO !== 32'h00A5_0000) begin fails++; $display("FAIL write_gpo got %h want %h", GPO, 32'h00A50000); end
    tests++; if (WR_PULSE !== 4'b0100) begin fails++; $display("FAIL write_pulse got %b want 0100", WR_PULSE); end
    tick();
    tests++; if (WR_PULSE !== 4'b0000) begin fails++; $display("FAIL write_pulse_end got %b want 0000", WR_PULSE); end
    tests++; if (GPO !== 32'h00A5_0000) begin fails++; $display("FAIL write_hold got %h want %h", GPO, 32'h00A50000); end
  endtask

  task automatic test_back_to_back();
    wr(8'h40, 8'h11);
    tests++; if (WR_PULSE !== 4'b0001) begin fails++; $display("FAIL b2b_pulse0 got %b want 0001", WR_PULSE); end
    wr(8'h43, 8'h22);
    tests++; if (WR_PULSE !== 4'b1000) begin fails++; $display("FAIL b2b_pulse3 got %b want 1000", WR_PULSE); end
    tests++; if (GPO !== 32'h22A5_0011) begin fails++; $display("FAIL b2b_gpo got %h want %h", GPO, 32'h22A50011); end
    tick();
    tests++; if (WR_PULSE !== 4'b0000) begin fails++; $display("FAIL b2b_pulse_end got %b want 0000", WR_PULSE); end
  endtask

  task automatic test_unmapped();
    wr(8'h21, 8'hFF);
    tests++; if (WR_PULSE !== 4'b0000) begin fails++; $display("FAIL in_range_wr_pulse got %b want 0000", WR_PULSE); end
    wr(8'h55, 8'hFF);
    wr(8'h44, 8'hFF);
    tests++; if (GPO !== 32'h22A5_0011) begin fails++; $display("FAIL unmapped_gpo got %h want %h", GPO, 32'h22A50011); end
    tests++; if (WR_PULSE !== 4'b0000) begin fails++; $display("FAIL unmapped_pulse got %b want 0000", WR_PULSE); end
  endtask

  task automatic test_gpi();
    logic [7:0] exp_rb;
    GPI = 32'h0000_3C00;
    setid(8'h21);
    tick();
    tests++; if (IN_PORT !== 8'h00) begin fails++; $display("FAIL gpi_lat1 got %h want 00", IN_PORT); end
    tick();
    tests++; if (IN_PORT !== 8'h3C) begin fails++; $display("FAIL gpi_lat2 got %h want 3c", IN_PORT); end
    setid(8'h20);
    tests++; if (IN_PORT !== 8'h00) begin fails++; $display("FAIL gpi_ch0 got %h want 00", IN_PORT); end
    setid(8'h55);
    tests++; if (IN_PORT !== 8'h00) begin fails++; $display("FAIL gpi_unmapped got %h want 00", IN_PORT); end
`ifdef RAT_IO_READBACK_EN
    exp_rb = 8'h11;
`else
    exp_rb = 8'h00;
`endif
    setid(8'h40);
    tests++; if (IN_PORT !== exp_rb) begin fails++; $display("FAIL readback_40 got %h want %h", IN_PORT, exp_rb); end
    PORT_ID = 8'h00;
  endtask

  task automatic test_irq();
    wr(8'hF1, 8'h01);
    setid(8'hF1);
    tests++; if (IN_PORT !== 8'h01) begin fails++; $display("FAIL mask_read got %h want 01", IN_PORT); end
    EVT = 4'b0001;
    tick(); tick();
    tests++; if (INTERRUPT !== 1'b0) begin fails++; $display("FAIL irq_early got %b want 0", INTERRUPT); end
    tick();
    setid(8'hF0);
    tests++; if (IN_PORT !== 8'h01) begin fails++; $display("FAIL pending_set got %h want 01", IN_PORT); end
    tests++; if (INTERRUPT !== 1'b0) begin fails++; $display("FAIL irq_lat3 got %b want 0", INTERRUPT); end
    tick();
    tests++; if (INTERRUPT !== 1'b1) begin fails++; $display("FAIL irq_lat4 got %b want 1", INTERRUPT); end
    wr(8'hF0, 8'h01);
    tests++; if (INTERRUPT !== 1'b1) begin fails++; $display("FAIL irq_w1c_edge got %b want 1", INTERRUPT); end
    setid(8'hF0);
    tests++; if (IN_PORT !== 8'h00) begin fails++; $display("FAIL w1c_clear got %h want 00", IN_PORT); end
    tick();
    tests++; if (INTERRUPT !== 1'b0) begin fails++; $display("FAIL irq_w1c_low got %b want 0", INTERRUPT); end
    tick(); tick(); tick();
    tests++; if (IN_PORT !== 8'h00) begin fails++; $display("FAIL held_evt_once got %h want 00", IN_PORT); end
  endtask

  task automatic test_masked_event();
    wr(8'hF1, 8'h00);
    EVT = 4'b0101;
    tick(); tick(); tick(); tick();
    setid(8'hF0);
    tests++; if (IN_PORT !== 8'h04) begin fails++; $display("FAIL masked_pending got %h want 04", IN_PORT); end
    tests++; if (INTERRUPT !== 1'b0) begin fails++; $display("FAIL masked_irq got %b want 0", INTERRUPT); end
    wr(8'hF1, 8'h04);
    tests++; if (INTERRUPT !== 1'b0) begin fails++; $display("FAIL unmask_edge got %b want 0", INTERRUPT); end
    tick();
    tests++; if (INTERRUPT !== 1'b1) begin fails++; $display("FAIL unmask_irq got %b want 1", INTERRUPT); end
  endtask

  task automatic test_set_wins();
    EVT = 4'b0111;
    tick(); tick(); tick();
    setid(8'hF0);
    tests++; if (IN_PORT !== 8'h06) begin fails++; $display("FAIL evt1_first got %h want 06", IN_PORT); end
    EVT = 4'b0101;
    tick(); tick(); tick(); tick();
    EVT = 4'b0111;
    tick(); tick();
    wr(8'hF0, 8'h06);
    setid(8'hF0);
    tests++; if (IN_PORT !== 8'h02) begin fails++; $display("FAIL set_wins got %h want 02", IN_PORT); end
    tick();
    tests++; if (INTERRUPT !== 1'b0) begin fails++; $display("FAIL set_wins_irq got %b want 0", INTERRUPT); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_rb;
    wr(8'hF1, 8'h0F);
    EVT = 4'b0000;
    tick(); tick(); tick(); tick();
    EVT = 4'b1111;
    tick(); tick(); tick(); tick();
    wr(8'h40, 8'hFF);
    setid(8'hF0);
    tests++; if (IN_PORT !== 8'h0F) begin fails++; $display("FAIL pre_reset_pending got %h want 0f", IN_PORT); end
    tests++; if (INTERRUPT !== 1'b1) begin fails++; $display("FAIL pre_reset_irq got %b want 1", INTERRUPT); end
    tests++; if (GPO[7:0] !== 8'hFF) begin fails++; $display("FAIL pre_reset_gpo got %h want ff", GPO[7:0]); end
    PORT_ID = 8'h41; OUT_PORT = 8'h99; IO_STRB = 1'b1;
    #2 RESET = 1'b1;
    #1;
    tests++; if (GPO !== 32'h0) begin fails++; $display("FAIL async_gpo got %h want 0", GPO); end
    tests++; if (INTERRUPT !== 1'b0) begin fails++; $display("FAIL async_irq got %b want 0", INTERRUPT); end
    tests++; if (WR_PULSE !== 4'h0) begin fails++; $display("FAIL async_pulse got %b want 0000", WR_PULSE); end
    IO_STRB = 1'b0;
    setid(8'hF0);
    tests++; if (IN_PORT !== 8'h00) begin fails++; $display("FAIL async_pending got %h want 00", IN_PORT); end
    tick();
    RESET = 1'b0;
    tick(); tick();
    tests++; if (IN_PORT !== 8'h00) begin fails++; $display("FAIL release_early got %h want 00", IN_PORT); end
    tick();
    tests++; if (IN_PORT !== 8'h0F) begin fails++; $display("FAIL release_pending got %h want 0f", IN_PORT); end
    tests++; if (GPO !== 32'h0) begin fails++; $display("FAIL inflight_dropped got %h want 0", GPO); end
    wr(8'h40, 8'h77);
`ifdef RAT_IO_READBACK_EN
    exp_rb = 8'h77;
`else
    exp_rb = 8'h00;
`endif
    setid(8'h40);
    tests++; if (IN_PORT !== exp_rb) begin fails++; $display("FAIL readback_77 got %h want %h", IN_PORT, exp_rb); end
  endtask

  initial begin
    RESET = 1'b1; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    GPI = 32'h0; EVT = 4'h0;
    test_reset();
    test_write();
    test_back_to_back();
    test_unmapped();
    test_gpi();
    test_irq();
    test_masked_event();
    test_set_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
